soc_system_pll_lock_monitor: RTL and testbench

//  Consumer end of the PLL's rst/locked interface. It drives pll_rst into the PLL and qualifies pll_locked.
//  sys_rst_n is released only after lock has been continuously stable; lock loss and relock timeouts are counted.

---
 rtl/soc_system_pll_pkg.sv | 34 +++
 rtl/soc_system_sync2.sv | 35 +++
 rtl/soc_system_pll_lock_monitor.sv | 165 ++++++++++++++++
 tb/tb_soc_system_pll_lock_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pll_pkg.sv
// Shared definitions for the soc_system PLL lock monitor.
// Holds the FSM state encoding, the default parameter values and a small
// elaboration-time helper used to size the shared cycle counter.
package soc_system_pll_pkg;

    // State encoding, kept as plain constants so other blocks can decode them
    localparam logic [1:0] S_PLL_RST   = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_STABLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    typedef enum logic [1:0] {
        StPllRst   = S_PLL_RST,
        StWaitLock = S_WAIT_LOCK,
        StStable   = S_STABLE,
        StRun      = S_RUN
    } pll_state_e;

    // Default parameter values for a 50 MHz reference clock
    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
    localparam int unsigned DEF_PLL_RST_CYCLES = 16;
    localparam int unsigned DEF_CNT_W          = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/soc_system_sync2.sv
// Generic two-flop synchroniser for a single-bit level signal.
// Ports:
//   clk     in   destination clock
//   reset_n in   asynchronous active-low reset, both flops go to RESET_VALUE
//   d       in   asynchronous input level
//   q       out  synchronised level, two clk edges after d is first sampled
module soc_system_sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    // Mark both stages as a synchroniser chain so placement keeps them adjacent
    // and timing analysis treats the first stage as metastability-prone.
    (* async_reg = "true", altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *)
    logic meta_q;
    (* async_reg = "true", altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *)
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/soc_system_pll_lock_monitor.sv
// PLL lock monitor for soc_system.
// Drives the PLL reset, qualifies the asynchronous locked flag and releases
// sys_rst_n only after lock has been continuously stable. Lock losses in RUN
// and relock timeouts are counted in saturating statistics counters.
// Clocked by the free-running board clock, never by the PLL output.
// Ports:
//   clk             in   free-running reference clock
//   reset_n         in   asynchronous active-low reset
//   pll_locked      in   PLL locked flag, asynchronous to clk
//   clear_stats     in   single-cycle pulse, zeroes both statistics counters
//   pll_rst         out  active-high reset to the PLL
//   sys_rst_n       out  active-low reset for the PLL clock domain
//   lock_ok         out  high exactly while in RUN
//   lock_loss_count out  RUN -> WAIT_LOCK transitions, saturating
//   timeout_count   out  WAIT_LOCK timeouts, saturating
module soc_system_pll_lock_monitor
    import soc_system_pll_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             clear_stats,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             lock_ok,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [CNT_W-1:0] timeout_count
);

    // One counter serves every timed state, so it is sized for the longest one
    localparam int unsigned MAX_CYCLES = max3(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES);
    localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

    localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

    pll_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              locked_s;
    logic              lock_loss_inc;
    logic              timeout_inc;
    logic              pll_rst_q;
    logic              sys_rst_n_q;
    logic              lock_ok_q;
    logic [CNT_W-1:0]  lock_loss_q, lock_loss_d;
    logic [CNT_W-1:0]  timeout_q, timeout_d;

    soc_system_sync2 #(
        .RESET_VALUE(1'b0)
    ) u_locked_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (pll_locked),
        .q      (locked_s)
    );

    // Clear wins over the old value but not over a same-cycle event, so a
    // collision leaves exactly one event recorded.
    function automatic logic [CNT_W-1:0] stat_next(input logic [CNT_W-1:0] cur,
                                                   input logic inc, input logic clr);
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = inc ? STAT_ONE : '0;
        end else if (inc && (cur != {CNT_W{1'b1}})) begin
            nxt = cur + STAT_ONE;
        end
        return nxt;
    endfunction

    // Next-state and counter decode; cnt restarts from zero on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StPllRst: begin
                // locked_s is deliberately ignored while the PLL is held in reset
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StPllRst;
                cnt_d   = '0;
            end
        endcase
    end

    // Statistics events are decoded from the current state, matching the
    // transitions taken above.
    always_comb begin
        lock_loss_inc = (state_q == StRun) && !locked_s;
        timeout_inc   = (state_q == StWaitLock) && !locked_s && (cnt_q == TIMEOUT_LAST);
        lock_loss_d   = stat_next(lock_loss_q, lock_loss_inc, clear_stats);
        timeout_d     = stat_next(timeout_q, timeout_inc, clear_stats);
    end

    // Outputs are loaded from the next-state decode so they change on the same
    // edge as the state register and never see an input combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StPllRst;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            lock_loss_q <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= (state_d == StPllRst);
            sys_rst_n_q <= (state_d == StRun);
            lock_ok_q   <= (state_d == StRun);
            lock_loss_q <= lock_loss_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst_n       = sys_rst_n_q;
    assign lock_ok         = lock_ok_q;
    assign lock_loss_count = lock_loss_q;
    assign timeout_count   = timeout_q;

endmodule

// File: tb/tb_soc_system_pll_lock_monitor.sv
// Scoreboard bench for soc_system_pll_lock_monitor with small parameters.
// The stimulus pushes each expected output transition (cycle stamp + values);
// a negedge monitor pops and compares whenever any output changes.
module tb_soc_system_pll_lock_monitor;

    localparam int unsigned STABLE_CYCLES  = 4;
    localparam int unsigned LOCK_TIMEOUT   = 8;
    localparam int unsigned PLL_RST_CYCLES = 3;
    localparam int unsigned CNT_W          = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             pll_locked;
    logic             clear_stats;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             lock_ok;
    logic [CNT_W-1:0] lock_loss_count;
    logic [CNT_W-1:0] timeout_count;

    soc_system_pll_lock_monitor #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .clear_stats    (clear_stats),
        .pll_rst        (pll_rst),
        .sys_rst_n      (sys_rst_n),
        .lock_ok        (lock_ok),
        .lock_loss_count(lock_loss_count),
        .timeout_count  (timeout_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic pll_rst;
        logic sys_rst_n;
        logic lock_ok;
        int   llc;
        int   toc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push_exp(int c, logic pr, logic sr, logic lo, int llc, int toc);
        exp_t e;
        e.cyc       = c;
        e.pll_rst   = pr;
        e.sys_rst_n = sr;
        e.lock_ok   = lo;
        e.llc       = llc;
        e.toc       = toc;
        exp_q.push_back(e);
    endfunction

    // Monitor: every output change must match the head of the expected queue
    logic [6:0] cur_vec, prev_vec, exp_vec;
    bit         mon_init = 0;
    exp_t       mon_e;

    always @(negedge clk) begin
        cur_vec = {pll_rst, sys_rst_n, lock_ok, lock_loss_count, timeout_count};
        if (!mon_init) begin
            prev_vec = cur_vec;
            mon_init = 1;
        end else if (cur_vec !== prev_vec) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: cyc=%0d got {rst,srn,ok,llc,toc}=%b, none expected",
                         cyc, cur_vec);
            end else begin
                mon_e   = exp_q.pop_front();
                exp_vec = {mon_e.pll_rst, mon_e.sys_rst_n, mon_e.lock_ok,
                           CNT_W'(mon_e.llc), CNT_W'(mon_e.toc)};
                if ((mon_e.cyc != cyc) || (cur_vec !== exp_vec)) begin
                    errors++;
                    $display("FAIL transition: got cyc=%0d out=%b, expected cyc=%0d out=%b",
                             cyc, cur_vec, mon_e.cyc, exp_vec);
                end
            end
            prev_vec = cur_vec;
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_pll_rst"}, int'(pll_rst), 1);
        check_val({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        check_val({tag, "_lock_ok"}, int'(lock_ok), 0);
        check_val({tag, "_lock_loss"}, int'(lock_loss_count), 0);
        check_val({tag, "_timeout"}, int'(timeout_count), 0);
    endtask

    // Must be called at a negedge; returns at the negedge where cyc == c
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    int k0, k1, k2, k3, k4, k5, k6, k7;

    initial begin
        reset_n     = 1'b1;
        pll_locked  = 1'b1;
        clear_stats = 1'b0;
        #1 reset_n  = 1'b0;
        #1 check_reset_vals("reset");

        repeat (3) @(negedge clk);

        // 1: release with lock already present; PLL_RST lasts 3 cycles, then
        //    WAIT_LOCK(1) + STABLE(4) before RUN
        k0 = cyc;
        push_exp(k0 + 3, 1'b0, 1'b0, 1'b0, 0, 0);
        push_exp(k0 + 8, 1'b0, 1'b1, 1'b1, 0, 0);
        reset_n = 1'b1;

        // 2+3: lose lock in RUN (3rd edge), then timeouts every 11 cycles
        wait_until(k0 + 10);
        k1 = cyc;
        push_exp(k1 + 3,  1'b0, 1'b0, 1'b0, 1, 0);
        push_exp(k1 + 11, 1'b1, 1'b0, 1'b0, 1, 1);
        push_exp(k1 + 14, 1'b0, 1'b0, 1'b0, 1, 1);
        push_exp(k1 + 22, 1'b1, 1'b0, 1'b0, 1, 2);
        push_exp(k1 + 25, 1'b0, 1'b0, 1'b0, 1, 2);
        push_exp(k1 + 33, 1'b1, 1'b0, 1'b0, 1, 3);
        push_exp(k1 + 36, 1'b0, 1'b0, 1'b0, 1, 3);
        push_exp(k1 + 44, 1'b1, 1'b0, 1'b0, 1, 3);
        push_exp(k1 + 47, 1'b0, 1'b0, 1'b0, 1, 3);
        pll_locked = 1'b0;

        // 4: 2-cycle lock glitch: STABLE at k2+3, back to WAIT_LOCK at k2+5,
        //    so the next timeout lands 8 edges later with no output activity before
        wait_until(k1 + 48);
        k2 = cyc;
        push_exp(k2 + 13, 1'b1, 1'b0, 1'b0, 1, 3);
        push_exp(k2 + 16, 1'b0, 1'b0, 1'b0, 1, 3);
        pll_locked = 1'b1;
        wait_until(k2 + 2);
        pll_locked = 1'b0;

        // Relock into RUN: STABLE_CYCLES+2 edges after the first sampling edge
        wait_until(k2 + 17);
        k3 = cyc;
        push_exp(k3 + 7, 1'b0, 1'b1, 1'b1, 1, 3);
        pll_locked = 1'b1;

        // 5: clear_stats coincides with a RUN lock loss
        wait_until(k3 + 9);
        k4 = cyc;
        push_exp(k4 + 3, 1'b0, 1'b0, 1'b0, 1, 0);
        pll_locked = 1'b0;
        wait_until(k4 + 2);
        clear_stats = 1'b1;
        wait_until(k4 + 3);
        clear_stats = 1'b0;

        // Relock, then clear_stats with no event zeroes both counters
        wait_until(k4 + 4);
        k5 = cyc;
        push_exp(k5 + 7, 1'b0, 1'b1, 1'b1, 1, 0);
        push_exp(k5 + 9, 1'b0, 1'b1, 1'b1, 0, 0);
        pll_locked = 1'b1;
        wait_until(k5 + 8);
        clear_stats = 1'b1;
        wait_until(k5 + 9);
        clear_stats = 1'b0;

        // 6: async reset between edges while in RUN
        wait_until(k5 + 10);
        k6 = cyc;
        push_exp(k6 + 1, 1'b1, 1'b0, 1'b0, 0, 0);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        wait_until(k6 + 3);
        k7 = cyc;
        push_exp(k7 + 3, 1'b0, 1'b0, 1'b0, 0, 0);
        push_exp(k7 + 8, 1'b0, 1'b1, 1'b1, 0, 0);
        reset_n = 1'b1;

        wait_until(k7 + 12);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_transitions: got %0d still outstanding, expected 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
